key_intr_port: RTL

KEY_INTR_PORT -- requirements
Module: key_intr_port

---
 rtl/key_intr_port.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/key_intr_port.sv
// key_intr_port: keypad-to-MCU bridge. Synchronizes the scanner's key-valid
// level, queues key codes in a 4-deep FIFO, exposes key/status bytes on the
// MCU input port and raises a fixed-length interrupt per pending key.
module key_intr_port #(
  parameter logic [7:0] KEY_PORT_ID  = 8'h30,
  parameter logic [7:0] STAT_PORT_ID = 8'h31,
  parameter int         INTR_LEN     = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] KEY_DATA,
  input  logic       KEY_PRESS,
  input  logic [7:0] PORT_ID,
  input  logic       RD_STRB,
  output logic [7:0] IN_PORT,
  output logic       INTR
);

  localparam logic [3:0] LEN_LOAD = 4'(INTR_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  // Synchronizer chain; the third flop only exists for edge detection.
  logic       sync1_q, sync2_q, sync3_q;

  // FIFO storage and bookkeeping.
  logic [3:0] mem_q [4];
  logic [3:0] mem_d [4];
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [2:0] count_q, count_d;
  logic       ovf_q, ovf_d;

  // Interrupt sequencer.
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       popped_q, popped_d;
  logic       intr_q, intr_d;

  logic       push, pop, full, wr_en, overflow;
  logic       key_sel, stat_sel, stat_rd;

  // Decode of the MCU access and the FIFO push/pop qualifiers.
  always_comb begin
    key_sel  = (PORT_ID == KEY_PORT_ID);
    stat_sel = (PORT_ID == STAT_PORT_ID);
    stat_rd  = RD_STRB & stat_sel;
    push     = sync2_q & ~sync3_q;
    pop      = RD_STRB & key_sel & (count_q != 3'd0);
    full     = (count_q == 3'd4);
    // A pop on the same edge frees the slot, so a push into a full FIFO
    // still lands when the head is being read out.
    wr_en    = push & (~full | pop);
    overflow = push & full & ~pop;
  end

  // Per-entry write enables; only the slot under the write pointer changes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mem
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (wr_en && (wptr_q == 2'(gi))) begin
          mem_d[gi] = KEY_DATA;
        end
      end
    end
  endgenerate

  // Pointer, occupancy and sticky-overflow next-state.
  always_comb begin
    wptr_d  = wptr_q + 2'(wr_en);
    rptr_d  = rptr_q + 2'(pop);
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    // Overflow is evaluated after the clear so a same-edge overflow wins.
    ovf_d = ovf_q;
    if (stat_rd) begin
      ovf_d = 1'b0;
    end
    if (overflow) begin
      ovf_d = 1'b1;
    end
  end

  // Interrupt sequencer next-state: one pulse of INTR_LEN cycles per key,
  // then wait for the MCU to read before issuing the next one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    popped_d = popped_q;
    case (state_q)
      IDLE: begin
        if (count_q != 3'd0) begin
          state_d  = ASSERT;
          cnt_d    = LEN_LOAD;
          popped_d = 1'b0;
        end
      end
      ASSERT: begin
        if (cnt_q == 4'd0) begin
          // A read seen during the pulse already acknowledged it.
          state_d  = (popped_q | pop) ? IDLE : WAIT_RD;
          popped_d = 1'b0;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          popped_d = popped_q | pop;
        end
      end
      WAIT_RD: begin
        if (pop) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        popped_d = 1'b0;
      end
    endcase
    intr_d = (state_d == ASSERT);
  end

  // Read mux toward the MCU.
  always_comb begin
    IN_PORT = 8'h00;
    if (key_sel) begin
      IN_PORT = (count_q != 3'd0) ? {4'h0, mem_q[rptr_q]} : 8'h00;
    end else if (stat_sel) begin
      IN_PORT = {ovf_q, 4'b0000, count_q};
    end
  end

  assign INTR = intr_q;

  // FIFO storage: contents need no reset, emptiness is tracked by count_q.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control state: reset overrides push, pop, clear and any running pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      wptr_q   <= 2'd0;
      rptr_q   <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      popped_q <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      sync1_q  <= KEY_PRESS;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      popped_q <= popped_d;
      intr_q   <= intr_d;
    end
  end

endmodule
